// File: rtl/operand_tf_pkg.sv
// Shared types for the operand transformer output path and its beat serializer.
package operand_tf_pkg;

  localparam int ELEM_WIDTH_OUT          = 8;
  localparam int OPTF_NUM_ELEMS          = 32;
  localparam int OPTF_SER_BEATS          = 4;
  localparam int OPTF_SER_ELEMS_PER_BEAT = 8;

  typedef struct packed {
    logic [OPTF_NUM_ELEMS-1:0][ELEM_WIDTH_OUT-1:0] flattened_elements;
  } operand_output_t;

  typedef logic [OPTF_SER_ELEMS_PER_BEAT-1:0][ELEM_WIDTH_OUT-1:0] ser_beat_t;

  // Element index carried by lane k of beat b: elements 8*b .. 8*b+7.
  function automatic logic [4:0] beat_elem_idx(input logic [1:0] beat, input logic [2:0] lane);
    return {beat, lane};
  endfunction

endpackage

// File: rtl/operand_tf_ser_if.sv
// Bus bundle between the operand transformer, the serializer and the beat consumer.
interface operand_tf_ser_if #(
  parameter int FIFO_DEPTH = 2
);
  import operand_tf_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Both sides use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid holds with stable payload until it is taken.
  logic              valid_in;
  logic              ready_in;
  operand_output_t   data_in;
  logic              valid_out;
  logic              ready_out;
  ser_beat_t         beat_data;
  logic [1:0]        beat_idx;
  logic              beat_last;
  logic [7:0]        beat_parity;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, beat_data, beat_idx, beat_last, beat_parity, fifo_level
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, beat_data, beat_idx, beat_last, beat_parity, fifo_level
  );

endinterface

// File: rtl/operand_tf_ser_fifo.sv
// Vector FIFO for the serializer: DEPTH full vectors, push at tail, pop at head.
module operand_tf_ser_fifo
  import operand_tf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int LVL_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  operand_output_t  push_data,
  input  logic             pop,
  output operand_output_t  head_data,
  output logic [LVL_W-1:0] level
);

  operand_output_t  mem_q [DEPTH];
  operand_output_t  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Local guards keep the level inside 0..DEPTH even if a caller misbehaves.
  assign do_push = push && (level_q != LVL_W'(DEPTH));
  assign do_pop  = pop && (level_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Payload storage is not reset; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/operand_tf_out_serializer.sv
// Buffers 32-element vectors and emits each as BEATS beats of 8 elements.
// Optional macro OPTF_SER_PARITY_EN adds per-lane even parity on beat_parity.
module operand_tf_out_serializer
  import operand_tf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int BEATS      = 4
) (
  input logic            clk,
  input logic            rst,
  operand_tf_ser_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [LVL_W-1:0] level;
  operand_output_t  head;
  logic             push;
  logic             pop;
  logic             vout;
  logic             last;
  logic [1:0]       beat_q, beat_d;
  ser_beat_t        beat;
  logic [7:0]       parity;

  // No bypass: a full FIFO refuses even while its head is being popped.
  assign bus.ready_in = (level < LVL_W'(FIFO_DEPTH)) && !rst;
  assign vout         = (level != '0) && !rst;
  assign push         = bus.valid_in && bus.ready_in;
  assign last         = (beat_q == 2'(BEATS - 1));
  assign pop          = vout && bus.ready_out && last;

  operand_tf_ser_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.data_in),
    .pop       (pop),
    .head_data (head),
    .level     (level)
  );

  always_comb begin
    beat_d = beat_q;
    if (vout && bus.ready_out) begin
      beat_d = last ? 2'd0 : beat_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  always_comb begin
    beat = '0;
    for (int k = 0; k < OPTF_SER_ELEMS_PER_BEAT; k++) begin
      beat[k] = head.flattened_elements[beat_elem_idx(beat_q, 3'(k))];
    end
  end

`ifdef OPTF_SER_PARITY_EN
  always_comb begin
    parity = '0;
    for (int k = 0; k < OPTF_SER_ELEMS_PER_BEAT; k++) begin
      parity[k] = ^beat[k];
    end
  end
`else
  assign parity = 8'h00;
`endif

  // Outputs are masked while idle or in reset so stale storage never shows.
  assign bus.valid_out   = vout;
  assign bus.beat_data   = vout ? beat : '0;
  assign bus.beat_idx    = vout ? beat_q : 2'd0;
  assign bus.beat_last   = vout && last;
  assign bus.beat_parity = vout ? parity : 8'h00;
  assign bus.fifo_level  = level;

endmodule
